// File: rtl/lambert_shader_if.sv
// Vector-pair request / grey-colour response bus for lambert_shader_seq.
// master = vector producer and colour consumer side; slave = the shader.
interface lambert_shader_if #(
    parameter int CW   = 11,
    parameter int CB   = 4,
    parameter int CHAN = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3*CW-1:0]      normal;
    logic [3*CW-1:0]      orient;
    logic                 out_valid;
    logic                 out_ready;
    logic [CHAN*CB-1:0]   color;
    logic                 degen;

    modport master (
        output in_valid, normal, orient, out_ready,
        input  in_ready, out_valid, color, degen
    );

    modport slave (
        input  in_valid, normal, orient, out_ready,
        output in_ready, out_valid, color, degen
    );
endinterface

// File: rtl/lambert_shader_seq.sv
// Clamped Lambertian intensity dot(n,l)/(|n||l|) via bit-serial sqrt and divide; 2CW+CB+5 cycles accept-to-valid,
// one pair in flight, colour held while out_ready is low. SHADER_AMBIENT_EN adds an AMBIENT intensity floor.
module lambert_shader_seq #(
    parameter int            CW      = 11,
    parameter int            CB      = 4,
    parameter int            CHAN    = 3,
    parameter logic [CB-1:0] AMBIENT = 4'd2
) (
    input  logic             clk,
    input  logic             rst,
    lambert_shader_if.slave  io
);
    localparam int DW  = 2*CW + 2;     // signed dot product
    localparam int MW  = 2*CW + 1;     // squared magnitudes
    localparam int RW  = 4*CW + 4;     // radicand, padded to even width
    localparam int SQ  = 2*CW + 2;     // root width and sqrt cycle count
    localparam int DRW = SQ + CB + 1;  // divider remainder / shifted divisor
    localparam int CTW = $clog2(SQ + 1);

`ifdef SHADER_AMBIENT_EN
    localparam bit AMB_ON = 1'b1;
`else
    localparam bit AMB_ON = 1'b0;
`endif
    localparam logic [CB-1:0] FLOOR = AMB_ON ? AMBIENT : '0;

    typedef enum logic [2:0] {IDLE, MUL, SQRT, DIV, OUT} state_t;

    state_t                state_q, state_d;
    logic [3*CW-1:0]       n_q, n_d, o_q, o_d;
    logic signed [DW-1:0]  dot_q, dot_d;
    logic [MW-1:0]         nn_q, nn_d, ll_q, ll_d;
    logic [RW-1:0]         rad_q, rad_d;
    logic [SQ-1:0]         rem_q, rem_d, root_q, root_d;
    logic [DRW-1:0]        drem_q, drem_d;
    logic [CB-1:0]         q_q, q_d;
    logic [CTW-1:0]        cnt_q, cnt_d;
    logic [CHAN*CB-1:0]    color_q, color_d;
    logic                  degen_q, degen_d;

    logic signed [DW-1:0]  nx, ny, nz, ox, oy, oz, dot_mul;
    logic [MW-1:0]         nn_mul, ll_mul;
    logic [RW-1:0]         rad_init, rad_cur;
    logic [SQ+1:0]         rem_sh, trial;
    logic [DRW-1:0]        num_init, drem_cur, den_sh;
    logic                  q_bit;
    logic [CB:0]           q_next;
    logic [CB-1:0]         inten;

    always_comb begin
        nx = DW'($signed(n_q[3*CW-1 -: CW]));
        ny = DW'($signed(n_q[2*CW-1 -: CW]));
        nz = DW'($signed(n_q[CW-1:0]));
        ox = DW'($signed(o_q[3*CW-1 -: CW]));
        oy = DW'($signed(o_q[2*CW-1 -: CW]));
        oz = DW'($signed(o_q[CW-1:0]));
        dot_mul = nx*ox + ny*oy + nz*oz;
        nn_mul  = MW'(nx*nx + ny*ny + nz*nz);
        ll_mul  = MW'(ox*ox + oy*oy + oz*oz);

        // First cycle of each iterative phase takes its operand straight from the MUL results.
        rad_init = RW'(nn_q) * RW'(ll_q);
        rad_cur  = (cnt_q == '0) ? rad_init : rad_q;
        rem_sh   = {rem_q, rad_cur[RW-1 -: 2]};
        trial    = {root_q, 2'b01};

        num_init = (dot_q > 0) ? (DRW'(dot_q) << CB) : '0;
        drem_cur = (cnt_q == '0) ? num_init : drem_q;
        den_sh   = DRW'(root_q) << (CB - int'(cnt_q));
        q_bit    = (root_q != '0) && (drem_cur >= den_sh);
        q_next   = {q_q, q_bit};

        inten = q_next[CB] ? '1 : q_next[CB-1:0];
        if (inten < FLOOR) inten = FLOOR;
        if (root_q == '0) inten = '0;
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        o_d     = o_q;
        dot_d   = dot_q;
        nn_d    = nn_q;
        ll_d    = ll_q;
        rad_d   = rad_q;
        rem_d   = rem_q;
        root_d  = root_q;
        drem_d  = drem_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        degen_d = degen_q;

        case (state_q)
            IDLE: begin
                if (io.in_valid) begin
                    n_d     = io.normal;
                    o_d     = io.orient;
                    state_d = MUL;
                end
            end
            MUL: begin
                dot_d   = dot_mul;
                nn_d    = nn_mul;
                ll_d    = ll_mul;
                rem_d   = '0;
                root_d  = '0;
                cnt_d   = '0;
                state_d = SQRT;
            end
            SQRT: begin
                rad_d = rad_cur << 2;
                if (rem_sh >= trial) begin
                    rem_d  = SQ'(rem_sh - trial);
                    root_d = {root_q[SQ-2:0], 1'b1};
                end else begin
                    rem_d  = SQ'(rem_sh);
                    root_d = {root_q[SQ-2:0], 1'b0};
                end
                if (cnt_q == CTW'(SQ - 1)) begin
                    cnt_d   = '0;
                    state_d = DIV;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DIV: begin
                drem_d = q_bit ? (drem_cur - den_sh) : drem_cur;
                q_d    = q_next[CB-1:0];
                if (cnt_q == CTW'(CB)) begin
                    color_d = {CHAN{inten}};
                    degen_d = (root_q == '0);
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OUT: begin
                if (io.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            o_q     <= '0;
            dot_q   <= '0;
            nn_q    <= '0;
            ll_q    <= '0;
            rad_q   <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            drem_q  <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            color_q <= '0;
            degen_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            o_q     <= o_d;
            dot_q   <= dot_d;
            nn_q    <= nn_d;
            ll_q    <= ll_d;
            rad_q   <= rad_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            drem_q  <= drem_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
            degen_q <= degen_d;
        end
    end

    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == OUT);
    assign io.color     = color_q;
    assign io.degen     = degen_q;
endmodule

// File: tb/tb_lambert_shader_seq.sv
// Bench for lambert_shader_seq: directed vector table, randomized pairs against an arithmetic model,
// plus backpressure and mid-transaction reset sequences.
module tb_lambert_shader_seq;
    localparam int LAT = 31;
`ifdef SHADER_AMBIENT_EN
    localparam bit AMB = 1'b1;
`else
    localparam bit AMB = 1'b0;
`endif
    localparam logic [11:0] DARK = AMB ? 12'h222 : 12'h000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lambert_shader_if #(.CW(11), .CB(4), .CHAN(3)) bus ();

    lambert_shader_seq #(.CW(11), .CB(4), .CHAN(3), .AMBIENT(4'd2)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    typedef struct {
        logic [32:0] n;
        logic [32:0] l;
        logic [11:0] col;
        logic        dg;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] pack3(input int x, input int y, input int z);
        return {11'(x), 11'(y), 11'(z)};
    endfunction

    function automatic int clampc(input int v);
        if (v > 1023) return 1023;
        if (v < -1024) return -1024;
        return v;
    endfunction

    // Reference: exact integer Lambert ratio from the vector definitions.
    function automatic void model(input logic [32:0] nv, input logic [32:0] lv,
                                 output logic [11:0] col, output logic dg);
        longint nx, ny, nz, lx, ly, lz, dot, nn, ll, r, den, q;
        logic [3:0] it;
        nx = longint'($signed(nv[32:22])); ny = longint'($signed(nv[21:11])); nz = longint'($signed(nv[10:0]));
        lx = longint'($signed(lv[32:22])); ly = longint'($signed(lv[21:11])); lz = longint'($signed(lv[10:0]));
        dot = nx*lx + ny*ly + nz*lz;
        nn  = nx*nx + ny*ny + nz*nz;
        ll  = lx*lx + ly*ly + lz*lz;
        r   = nn * ll;
        den = longint'($floor($sqrt(real'(r))));
        while (den * den > r) den--;
        while ((den + 1) * (den + 1) <= r) den++;
        dg = (den == 0);
        if (dg) begin
            it = 4'd0;
        end else begin
            q  = (dot > 0) ? (dot * 16) / den : 0;
            it = (q >= 16) ? 4'd15 : 4'(q);
            if (AMB && it < 4'd2) it = 4'd2;
        end
        col = {3{it}};
    endfunction

    task automatic run_txn(input string name, input logic [32:0] nv, input logic [32:0] lv,
                           input logic [11:0] ecol, input logic edg);
        int j;
        @(negedge clk);
        check($sformatf("%s_in_ready", name), bus.in_ready, 1);
        bus.normal    = nv;
        bus.orient    = lv;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        j = 0;
        do begin
            @(negedge clk);
            j++;
            if (j == 1) begin
                bus.in_valid = 1'b0;
                bus.normal   = 33'($urandom);
                bus.orient   = 33'($urandom);
            end
        end while (!bus.out_valid && j < 100);
        check($sformatf("%s_latency", name), j, LAT);
        check($sformatf("%s_color", name), bus.color, ecol);
        check($sformatf("%s_degen", name), bus.degen, edg);
        @(negedge clk);
        check($sformatf("%s_valid_drop", name), bus.out_valid, 0);
        check($sformatf("%s_ready_back", name), bus.in_ready, 1);
        check($sformatf("%s_color_hold", name), bus.color, ecol);
    endtask

    initial begin
        vec_t tbl[10];
        logic [32:0] nv, lv;
        logic [11:0] mcol;
        logic        mdg;
        logic        seen;
        int          j;

        tbl[0] = '{pack3(0, 0, 100),          pack3(0, 0, 50),          12'hFFF, 1'b0};
        tbl[1] = '{pack3(100, 0, 0),          pack3(100, 100, 0),       12'hBBB, 1'b0};
        tbl[2] = '{pack3(3, 4, 0),            pack3(4, 3, 0),           12'hFFF, 1'b0};
        tbl[3] = '{pack3(100, 0, 0),          pack3(-100, 0, 0),        DARK,    1'b0};
        tbl[4] = '{pack3(0, 0, 0),            pack3(5, 5, 5),           12'h000, 1'b1};
        tbl[5] = '{pack3(-1024, -1024, -1024), pack3(-1024, -1024, -1024), 12'hFFF, 1'b0};
        tbl[6] = '{pack3(1, 0, 0),            pack3(1, 1, 0),           12'hFFF, 1'b0};
        tbl[7] = '{pack3(100, 0, 0),          pack3(0, 100, 0),         DARK,    1'b0};
        tbl[8] = '{pack3(-1024, 0, 0),        pack3(1023, 0, 0),        DARK,    1'b0};
        tbl[9] = '{pack3(10, 0, 0),           pack3(10, 10, 10),        12'h999, 1'b0};

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.normal    = '0;
        bus.orient    = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_color",     bus.color, 0);
        check("rst_degen",     bus.degen, 0);
        rst = 1'b1;

        for (int i = 0; i < 10; i++)
            run_txn($sformatf("vec%0d", i), tbl[i].n, tbl[i].l, tbl[i].col, tbl[i].dg);

        for (int i = 0; i < 30; i++) begin
            int nx, ny, nz;
            nx = int'($urandom_range(0, 2047)) - 1024;
            ny = int'($urandom_range(0, 2047)) - 1024;
            nz = int'($urandom_range(0, 2047)) - 1024;
            nv = pack3(nx, ny, nz);
            if (i % 2 == 1)
                lv = pack3(clampc(nx + int'($urandom_range(0, 200)) - 100),
                           clampc(ny + int'($urandom_range(0, 200)) - 100),
                           clampc(nz + int'($urandom_range(0, 200)) - 100));
            else
                lv = pack3(int'($urandom_range(0, 2047)) - 1024,
                           int'($urandom_range(0, 2047)) - 1024,
                           int'($urandom_range(0, 2047)) - 1024);
            model(nv, lv, mcol, mdg);
            run_txn($sformatf("rnd%0d", i), nv, lv, mcol, mdg);
        end

        // Backpressure: output held, new request ignored, single handshake on release.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.normal    = pack3(3, 4, 0);
        bus.orient    = pack3(4, 3, 0);
        bus.in_valid  = 1'b1;
        j = 0;
        do begin
            @(negedge clk);
            j++;
            if (j == 1) bus.in_valid = 1'b0;
        end while (!bus.out_valid && j < 100);
        check("bp_latency", j, LAT);
        for (int k = 0; k < 10; k++) begin
            check("bp_valid_held", bus.out_valid, 1);
            check("bp_color_held", bus.color, 12'hFFF);
            check("bp_in_ready",   bus.in_ready, 0);
            bus.in_valid = 1'b1;
            bus.normal   = pack3(0, 0, 0);
            bus.orient   = pack3(5, 5, 5);
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_drop", bus.out_valid, 0);
        check("bp_ready_back", bus.in_ready, 1);
        check("bp_color_keep", bus.color, 12'hFFF);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("bp_no_ghost_txn", seen, 0);

        // Reset at T+12 abandons the transaction.
        @(negedge clk);
        bus.normal   = pack3(1, 0, 0);
        bus.orient   = pack3(1, 1, 0);
        bus.in_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) bus.in_valid = 1'b0;
        end
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready",  bus.in_ready, 1);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_color",     bus.color, 0);
        check("mid_rst_degen",     bus.degen, 0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("mid_rst_no_output", seen, 0);

        run_txn("after_rst", tbl[1].n, tbl[1].l, tbl[1].col, tbl[1].dg);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
